mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF, read-only) and the load/store unit (DM).
- Loads and stores come from ctrl_t load/store decode.
- One outstanding transaction at a time. Fixed data priority with a fetch anti-starvation counter.
- Sits between the pipeline front/back ends and the external memory bus.

Parameters:
STARVE_MAX, 4, number of consecutive DM grants allowed while if_req is pending before IF is forced to win (range 1..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  32  fetch word address
if_gnt  out  1  fetch request accepted by memory this cycle
if_rvalid  out  1  fetch response valid
if_rdata  out  32  fetch response data (mem_rdata passthrough)
dm_req  in  1  load/store request; held with fields until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  data address
dm_wdata  in  32  store data
dm_be  in  4  store byte enables
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  load data / store acknowledge valid
dm_rdata  out  32  load data (mem_rdata passthrough)
mem_req  out  1  memory request
mem_we  out  1  memory write enable (0 for fetch)
mem_addr  out  32  memory address
mem_wdata  out  32  write data (0 for fetch)
mem_be  out  4  byte enables (4'hF for fetch)
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response (every request, including stores, gets exactly one)
mem_rdata  in  32  memory response data

Behaviour:
- State register: IDLE, REQ_IF, REQ_DM, WAIT_IF, WAIT_DM. Also holds a 4-bit starve_cnt. All reset asynchronously to IDLE / 0.
- While reset is high: mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid are 0. Other outputs are don't-care.
- IDLE: select owner combinationally in the same cycle.
  - DM wins if dm_req && !(if_req && starve_cnt == STARVE_MAX).
  - Otherwise IF wins if if_req.
  - If nothing is requested, mem_req = 0.
  - The winner's fields drive mem_*, and mem_req = 1.
  - If mem_gnt: the owner's gnt = 1 (same cycle), go to WAIT_x.
  - Else go to REQ_x (owner locked).
- REQ_IF / REQ_DM: owner is locked. mem_req stays high with the same owner's fields; the other requester is ignored.
  - On mem_gnt: assert that owner's gnt and go to WAIT_x.
- WAIT_IF / WAIT_DM: mem_req = 0.
  - On mem_rvalid: the matching x_rvalid = 1 in the same cycle, then IDLE.
  - Earliest next request is the following cycle. Throughput is at most 1 transaction per 2 cycles.
- starve_cnt updates on each grant:
  - DM grant with if_req high: saturating +1.
  - DM grant with if_req low: cleared.
  - IF grant: cleared.
- mem_rvalid in IDLE/REQ_x (stray) is ignored: no rvalid to either side.
- A requester dropping req while locked in REQ_x is a protocol violation; behaviour is undefined.
- if_rdata and dm_rdata are always mem_rdata. Only the rvalids are routed.
- Reset mid-operation abandons any outstanding transaction. Its late mem_rvalid arrives in IDLE and is dropped.

Optional Feature:
- Macro: MEM_ARBITER_FLUSH_EN.
- When defined:
  - Adds input if_flush (1 bit). The pipeline asserts it on taken jump/branch.
  - if_flush high in WAIT_IF, or in the cycle of the IF grant, sets a kill flag.
  - The resulting response still returns the FSM to IDLE, but if_rvalid is held 0. The kill flag clears on that mem_rvalid.
  - if_flush in REQ_IF does not withdraw the request.
- When undefined: the port is absent and every fetch response is forwarded.

Test Plan:
- Solo fetch: if_req=1, if_addr=0x100, mem_gnt=1 in cycle 0, mem_rvalid=1 with rdata=0x00000013 in cycle 2 -> if_gnt=1 in cycle 0, mem_addr=0x100, mem_be=4'hF, if_rvalid=1 and if_rdata=0x13 in cycle 2, dm_rvalid=0 throughout.
- Contention: if_req and dm_req (store, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011) rise together, mem_gnt always 1, rvalid 1 cycle after each grant -> DM granted cycle 0 with mem_we=1, dm_rvalid cycle 1, IF granted cycle 2.
- Starvation with STARVE_MAX=4: dm_req and if_req held high continuously -> grants DM,DM,DM,DM,IF,DM..., starve_cnt returns to 0 after the IF grant.
- Backpressure: IF wins, mem_gnt=0 for 3 cycles while dm_req rises in cycle 1 -> mem_addr stays if_addr, no dm_gnt; if_gnt on cycle 3 when mem_gnt=1.
- Reset mid-op: reset pulsed during WAIT_DM, then mem_rvalid=1 a cycle after release -> dm_rvalid=0, if_rvalid=0, state IDLE, next if_req granted normally.
- Flush (MEM_ARBITER_FLUSH_EN): fetch granted, if_flush=1 one cycle later, mem_rvalid two cycles later -> if_rvalid stays 0, FSM IDLE, next fetch response forwarded with if_rvalid=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-port signals of mem_arbiter.
// if_flush exists only when MEM_ARBITER_FLUSH_EN is defined.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
`ifdef MEM_ARBITER_FLUSH_EN
    logic        if_flush;
`endif
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
`ifdef MEM_ARBITER_FLUSH_EN
        input  if_flush,
`endif
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr,
`ifdef MEM_ARBITER_FLUSH_EN
        output if_flush,
`endif
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data first with fetch anti-starvation.
// MEM_ARBITER_FLUSH_EN adds if_flush, which drops the response of a fetch killed by a taken branch.
module mem_arbiter #(
    parameter logic [3:0] STARVE_MAX = 4'd4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ_IF  = 3'd1;
    localparam logic [2:0] REQ_DM  = 3'd2;
    localparam logic [2:0] WAIT_IF = 3'd3;
    localparam logic [2:0] WAIT_DM = 3'd4;

    logic [2:0] state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       own_dm, req, gnt, kill_now;

    always_comb begin
        own_dm = state == REQ_DM ||
                 (state == IDLE && bus.dm_req && !(bus.if_req && starve_cnt == STARVE_MAX));
        req = !reset && (state == REQ_IF || state == REQ_DM ||
                         (state == IDLE && (bus.if_req || bus.dm_req)));
        gnt = req && bus.mem_gnt;
        state_nxt = req ? (own_dm ? (gnt ? WAIT_DM : REQ_DM) : (gnt ? WAIT_IF : REQ_IF)) :
                    ((state == WAIT_IF || state == WAIT_DM) && !bus.mem_rvalid) ? state : IDLE;
        // the counter saturates at STARVE_MAX so the equality test always forces fetch through
        starve_nxt = (gnt && own_dm) ?
                     (bus.if_req ? starve_cnt + {3'd0, starve_cnt != STARVE_MAX} : 4'd0) :
                     gnt ? 4'd0 : starve_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign bus.mem_req   = req;
    assign bus.if_gnt    = gnt && !own_dm;
    assign bus.dm_gnt    = gnt && own_dm;
    assign bus.mem_we    = own_dm && bus.dm_we;
    assign bus.mem_addr  = own_dm ? bus.dm_addr : bus.if_addr;
    assign bus.mem_wdata = own_dm ? bus.dm_wdata : 32'd0;
    assign bus.mem_be    = own_dm ? bus.dm_be : 4'hF;
    assign bus.if_rvalid = state == WAIT_IF && bus.mem_rvalid && !kill_now;
    assign bus.dm_rvalid = state == WAIT_DM && bus.mem_rvalid;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

`ifdef MEM_ARBITER_FLUSH_EN
    logic kill;
    assign kill_now = kill || (state == WAIT_IF && bus.if_flush);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            kill <= 1'b0;
        else if (state == WAIT_IF && bus.mem_rvalid)
            kill <= 1'b0;
        else if (bus.if_flush && (state == WAIT_IF || bus.if_gnt))
            kill <= 1'b1;
    end
`else
    assign kill_now = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level arbiter model.
module tb_mem_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [4:0] ctl;

    mem_arbiter_if b();
    mem_arbiter #(.STARVE_MAX(4'(SM))) dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    assign ctl = {b.mem_req, b.if_gnt, b.dm_gnt, b.if_rvalid, b.dm_rvalid};

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic quiet();
        b.if_req = 0; b.if_addr = 0;
        b.dm_req = 0; b.dm_we = 0; b.dm_addr = 0; b.dm_wdata = 0; b.dm_be = 0;
        b.mem_gnt = 0; b.mem_rvalid = 0; b.mem_rdata = 0;
`ifdef MEM_ARBITER_FLUSH_EN
        b.if_flush = 0;
`endif
    endtask

    task automatic test_reset();
        quiet();
        reset = 1;
        nxt();
        b.if_req = 1; b.dm_req = 1; b.mem_gnt = 1; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL reset_outputs got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
        nxt();
        quiet();
        reset = 0;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL idle_after_reset got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
    endtask

    task automatic test_solo_fetch();
        nxt();
        b.if_req = 1; b.if_addr = 32'h100; b.mem_gnt = 1;
        #1;
        if (ctl !== 5'b11000) begin $display("FAIL solo_gnt got=%b want=%b", ctl, 5'b11000); bad++; end
        total++;
        if ({b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be} !== {1'b0, 32'h100, 32'h0, 4'hF}) begin
            $display("FAIL solo_fields got=%h want=%h", {b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be},
                     {1'b0, 32'h100, 32'h0, 4'hF});
            bad++;
        end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL solo_wait got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
        nxt();
        b.mem_rvalid = 1; b.mem_rdata = 32'h13;
        #1;
        if ({ctl, b.if_rdata} !== {5'b00010, 32'h13}) begin
            $display("FAIL solo_rvalid got=%b/%h want=%b/%h", ctl, b.if_rdata, 5'b00010, 32'h13);
            bad++;
        end
        total++;
        nxt();
        quiet();
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL solo_idle got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
    endtask

    task automatic test_contention();
        nxt();
        b.if_req = 1; b.if_addr = 32'h104;
        b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h2000; b.dm_wdata = 32'hDEADBEEF; b.dm_be = 4'b0011;
        b.mem_gnt = 1;
        #1;
        if (ctl !== 5'b10100) begin $display("FAIL cont_dm_gnt got=%b want=%b", ctl, 5'b10100); bad++; end
        total++;
        if ({b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be} !== {1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
            $display("FAIL cont_fields got=%h want=%h", {b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be},
                     {1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011});
            bad++;
        end
        total++;
        nxt();
        b.dm_req = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00001) begin $display("FAIL cont_dm_rvalid got=%b want=%b", ctl, 5'b00001); bad++; end
        total++;
        nxt();
        b.mem_rvalid = 0;
        #1;
        if ({ctl, b.mem_addr} !== {5'b11000, 32'h104}) begin
            $display("FAIL cont_if_gnt got=%b/%h want=%b/%h", ctl, b.mem_addr, 5'b11000, 32'h104);
            bad++;
        end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00010) begin $display("FAIL cont_if_rvalid got=%b want=%b", ctl, 5'b00010); bad++; end
        total++;
        nxt();
        quiet();
    endtask

    task automatic test_starvation();
        logic [9:0] want_if = 10'b1000010000;
        nxt();
        quiet();
        b.if_req = 1; b.if_addr = 32'h200; b.dm_req = 1; b.dm_addr = 32'h3000; b.mem_gnt = 1;
        for (int i = 0; i < 10; i++) begin
            b.mem_rvalid = 0;
            #1;
            if ({b.if_gnt, b.dm_gnt} !== (want_if[i] ? 2'b10 : 2'b01)) begin
                $display("FAIL starve_grant n=%0d got=%b want=%b", i, {b.if_gnt, b.dm_gnt},
                         want_if[i] ? 2'b10 : 2'b01);
                bad++;
            end
            total++;
            nxt();
            b.mem_rvalid = 1;
            nxt();
        end
        quiet();
    endtask

    task automatic test_backpressure();
        nxt();
        b.if_req = 1; b.if_addr = 32'h300;
        #1;
        if ({ctl, b.mem_addr} !== {5'b10000, 32'h300}) begin
            $display("FAIL bp_req got=%b/%h want=%b/%h", ctl, b.mem_addr, 5'b10000, 32'h300);
            bad++;
        end
        total++;
        for (int i = 1; i < 3; i++) begin
            nxt();
            b.dm_req = 1; b.dm_addr = 32'h400;
            #1;
            if ({ctl, b.mem_addr, b.mem_we} !== {5'b10000, 32'h300, 1'b0}) begin
                $display("FAIL bp_locked n=%0d got=%b/%h want=%b/%h", i, ctl, b.mem_addr, 5'b10000, 32'h300);
                bad++;
            end
            total++;
        end
        nxt();
        b.mem_gnt = 1;
        #1;
        if ({ctl, b.mem_addr} !== {5'b11000, 32'h300}) begin
            $display("FAIL bp_if_gnt got=%b/%h want=%b/%h", ctl, b.mem_addr, 5'b11000, 32'h300);
            bad++;
        end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00010) begin $display("FAIL bp_if_rvalid got=%b want=%b", ctl, 5'b00010); bad++; end
        total++;
        nxt();
        b.mem_rvalid = 0; b.mem_gnt = 1;
        #1;
        if ({ctl, b.mem_addr} !== {5'b10100, 32'h400}) begin
            $display("FAIL bp_dm_gnt got=%b/%h want=%b/%h", ctl, b.mem_addr, 5'b10100, 32'h400);
            bad++;
        end
        total++;
        nxt();
        b.dm_req = 0; b.mem_gnt = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00001) begin $display("FAIL bp_dm_rvalid got=%b want=%b", ctl, 5'b00001); bad++; end
        total++;
        nxt();
        quiet();
    endtask

    task automatic test_reset_midop();
        nxt();
        b.dm_req = 1; b.dm_addr = 32'h500; b.mem_gnt = 1;
        #1;
        if (ctl !== 5'b10100) begin $display("FAIL midop_gnt got=%b want=%b", ctl, 5'b10100); bad++; end
        total++;
        nxt();
        b.dm_req = 0; b.mem_gnt = 0; reset = 1;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL midop_reset got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
        nxt();
        reset = 0;
        nxt();
        b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL midop_stray got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
        nxt();
        b.mem_rvalid = 0; b.if_req = 1; b.if_addr = 32'h600; b.mem_gnt = 1;
        #1;
        if ({ctl, b.mem_addr} !== {5'b11000, 32'h600}) begin
            $display("FAIL midop_next got=%b/%h want=%b/%h", ctl, b.mem_addr, 5'b11000, 32'h600);
            bad++;
        end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00010) begin $display("FAIL midop_rvalid got=%b want=%b", ctl, 5'b00010); bad++; end
        total++;
        nxt();
        quiet();
    endtask

`ifdef MEM_ARBITER_FLUSH_EN
    task automatic test_flush();
        nxt();
        b.if_req = 1; b.if_addr = 32'h700; b.mem_gnt = 1;
        #1;
        if (ctl !== 5'b11000) begin $display("FAIL flush_gnt got=%b want=%b", ctl, 5'b11000); bad++; end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0; b.if_flush = 1;
        nxt();
        b.if_flush = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00000) begin $display("FAIL flush_killed got=%b want=%b", ctl, 5'b0); bad++; end
        total++;
        nxt();
        b.mem_rvalid = 0; b.if_req = 1; b.mem_gnt = 1;
        #1;
        if (ctl !== 5'b11000) begin $display("FAIL flush_next_gnt got=%b want=%b", ctl, 5'b11000); bad++; end
        total++;
        nxt();
        b.if_req = 0; b.mem_gnt = 0; b.mem_rvalid = 1;
        #1;
        if (ctl !== 5'b00010) begin $display("FAIL flush_next_rvalid got=%b want=%b", ctl, 5'b00010); bad++; end
        total++;
        nxt();
        quiet();
    endtask
`endif

    // Model: who is waiting on a response, who holds a stalled request, and how long fetch has waited.
    task automatic test_random();
        int out_own = 0, lock = 0, starve = 0, owner;
        logic if_p = 0, dm_p = 0;
        logic [4:0] e_ctl;
        logic [68:0] e_fld;
        nxt();
        quiet();
        reset = 1;
        nxt();
        reset = 0;
        for (int i = 0; i < 600; i++) begin
            nxt();
            if (!if_p && $urandom_range(0, 2) == 0) begin
                if_p = 1; b.if_addr = $urandom;
            end
            if (!dm_p && $urandom_range(0, 2) == 0) begin
                dm_p = 1; b.dm_we = 1'($urandom_range(0, 1)); b.dm_addr = $urandom;
                b.dm_wdata = $urandom; b.dm_be = 4'($urandom);
            end
            b.if_req = if_p;
            b.dm_req = dm_p;
            b.mem_gnt = $urandom_range(0, 2) != 0;
            b.mem_rvalid = out_own != 0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            b.mem_rdata = $urandom;
            owner = out_own != 0 ? 0 : lock != 0 ? lock : (dm_p && !(if_p && starve == SM)) ? 2 : if_p ? 1 : 0;
            e_ctl = {owner != 0, owner == 1 && b.mem_gnt, owner == 2 && b.mem_gnt,
                     out_own == 1 && b.mem_rvalid, out_own == 2 && b.mem_rvalid};
            e_fld = owner == 2 ? {b.dm_we, b.dm_addr, b.dm_wdata, b.dm_be} : {1'b0, b.if_addr, 32'h0, 4'hF};
            #1;
            if (ctl !== e_ctl) begin
                $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", i, ctl, e_ctl);
                bad++;
            end
            total++;
            if (owner != 0) begin
                if ({b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be} !== e_fld) begin
                    $display("FAIL rnd_fields cyc=%0d got=%h want=%h", i,
                             {b.mem_we, b.mem_addr, b.mem_wdata, b.mem_be}, e_fld);
                    bad++;
                end
                total++;
            end
            if ({b.if_rdata, b.dm_rdata} !== {b.mem_rdata, b.mem_rdata}) begin
                $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h", i, b.if_rdata, b.dm_rdata, b.mem_rdata);
                bad++;
            end
            total++;
            if (out_own != 0) begin
                if (b.mem_rvalid) out_own = 0;
            end else if (owner != 0) begin
                if (b.mem_gnt) begin
                    starve = (owner == 1 || !if_p) ? 0 : (starve < SM ? starve + 1 : SM);
                    if (owner == 1) if_p = 0; else dm_p = 0;
                    out_own = owner;
                    lock = 0;
                end else begin
                    lock = owner;
                end
            end
        end
        nxt();
        quiet();
    endtask

    initial begin
        test_reset();
        test_solo_fetch();
        test_contention();
        test_starvation();
        test_backpressure();
        test_reset_midop();
`ifdef MEM_ARBITER_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
